// File: rtl/fifo_rd_drain_if.sv
// Drain-engine bundle: FIFO read-side pop/data plus downstream valid/ready and status.
interface fifo_rd_drain_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
);
  logic                  en;
  logic                  rempty;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rinc;
  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_ready;
  logic                  busy;
  logic [CNT_WIDTH-1:0]  pop_cnt;

  modport master (
    input  en, rempty, rdata, m_ready,
    output rinc, m_valid, m_data, busy, pop_cnt
  );

  modport slave (
    output en, rempty, rdata, m_ready,
    input  rinc, m_valid, m_data, busy, pop_cnt
  );
endinterface

// File: rtl/fifo_rd_drain.sv
// Read-side drain: one-cycle rinc pops into a 2-entry output buffer; word valid one edge after rinc.
// Stops popping while the buffer holds 2 words; m_data held while m_valid && !m_ready.
module fifo_rd_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input logic             R_CLK,
  input logic             R_RST,
  fifo_rd_drain_if.master bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] POP  = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  logic [1:0]            state;
  logic                  rinc_q;
  logic [DATA_WIDTH-1:0] buf_mem [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            occ;
  logic [CNT_WIDTH-1:0]  cnt;

  logic launch;
  logic capture;
  logic deq;

  // occ is sampled before any same-edge dequeue, so at most one capture can land on occ<=1
  assign launch  = (state == IDLE) && bus.en && !bus.rempty && (occ != 2'd2);
  assign capture = (state == POP);
  assign deq     = (occ != 2'd0) && bus.m_ready;

  always_ff @(posedge R_CLK or negedge R_RST) begin
    if (!R_RST) begin
      state  <= IDLE;
      rinc_q <= 1'b0;
    end else begin
      case (state)
        IDLE:    state <= launch ? POP : IDLE;
        POP:     state <= GAP;
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
      rinc_q <= launch;
    end
  end

  always_ff @(posedge R_CLK or negedge R_RST) begin
    if (!R_RST) begin
      buf_mem[0] <= '0;
      buf_mem[1] <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      occ        <= 2'd0;
      cnt        <= '0;
    end else begin
      if (capture) begin
        buf_mem[wr_ptr] <= bus.rdata;
        wr_ptr          <= ~wr_ptr;
        cnt             <= cnt + CNT_WIDTH'(1);
      end
      if (deq) begin
        rd_ptr <= ~rd_ptr;
      end
      occ <= occ + 2'(capture) - 2'(deq);
    end
  end

  assign bus.rinc    = rinc_q;
  assign bus.busy    = rinc_q;
  assign bus.m_valid = (occ != 2'd0);
  assign bus.m_data  = buf_mem[rd_ptr];
  assign bus.pop_cnt = cnt;
endmodule

// File: tb/tb_fifo_rd_drain.sv
// Bench for fifo_rd_drain: queue-based FIFO/consumer model, directed phases plus random traffic.
module tb_fifo_rd_drain;
  localparam int DW = 8;
  localparam int CW = 4;

  logic R_CLK;
  logic R_RST;

  fifo_rd_drain_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  fifo_rd_drain #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .R_CLK (R_CLK),
    .R_RST (R_RST),
    .bus   (bus)
  );

  initial begin
    R_CLK = 1'b0;
    forever #5 R_CLK = ~R_CLK;
  end

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] src[$];     // words held in the modelled async FIFO
  logic [DW-1:0] exp_q[$];   // words captured but not yet accepted downstream
  int   pops;
  int   low_cnt;
  bit   prev_rinc;
  bit   hs_prev;
  bit   en_r;
  bit   rdy_r;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // One cycle: settle the model for the edge just taken, compare, then drive the next cycle.
  task automatic tick();
    bit legal;
    bit exp_rinc;
    @(negedge R_CLK);
    if (!R_RST) begin
      check("rst_rinc", bus.rinc, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_valid", bus.m_valid, 0);
      check("rst_data", bus.m_data, 0);
      check("rst_cnt", bus.pop_cnt, 0);
      src.delete();
      exp_q.delete();
      pops      = 0;
      low_cnt   = 2;
      prev_rinc = 0;
    end else begin
      legal    = bus.en && !bus.rempty && (exp_q.size() < 2);
      exp_rinc = (low_cnt >= 2) && legal;
      if (hs_prev && exp_q.size() > 0) void'(exp_q.pop_front());
      if (prev_rinc && src.size() > 0) begin
        exp_q.push_back(src.pop_front());
        pops++;
      end
      check("rinc", bus.rinc, exp_rinc);
      check("busy", bus.busy, exp_rinc);
      check("pop_cnt", bus.pop_cnt, pops % (1 << CW));
      check("m_valid", bus.m_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) check("m_data", bus.m_data, exp_q[0]);
      if (bus.rinc) low_cnt = 0;
      else if (low_cnt < 2) low_cnt++;
      prev_rinc = bus.rinc;
    end
    bus.en      = en_r;
    bus.m_ready = rdy_r;
    bus.rempty  = (src.size() == 0);
    bus.rdata   = (src.size() == 0) ? DW'($urandom) : src[0];
    hs_prev     = bus.m_valid && bus.m_ready;
  endtask

  task automatic drain(input string tag);
    bit done;
    en_r  = 1;
    rdy_r = 1;
    done  = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      tick();
      done = (src.size() == 0) && (exp_q.size() == 0) && (low_cnt >= 2);
    end
    check(tag, done, 1);
  endtask

  task automatic wait_rinc(input string tag);
    for (int i = 0; i < 30 && !bus.rinc; i++) tick();
    check(tag, bus.rinc, 1);
  endtask

  logic [DW-1:0] first_word;

  initial begin
    R_RST = 1'b0;
    pops = 0; low_cnt = 2; prev_rinc = 0; hs_prev = 0;
    en_r = 0; rdy_r = 0;
    bus.en = 0; bus.m_ready = 0; bus.rempty = 1; bus.rdata = '0;

    // reset with random inputs, then idle with an empty FIFO
    for (int i = 0; i < 4; i++) begin
      en_r  = 1'($urandom);
      rdy_r = 1'($urandom);
      tick();
    end
    R_RST = 1'b1;
    en_r = 1; rdy_r = 1;
    repeat (20) tick();

    // single word
    src.push_back(8'hA5);
    repeat (6) tick();
    check("single_cnt", bus.pop_cnt, 1);

    // streaming 1..6
    for (int w = 1; w <= 6; w++) src.push_back(DW'(w));
    drain("stream_done");
    check("stream_cnt", bus.pop_cnt, 7);

    // backpressure: only two pops fit
    rdy_r = 0;
    first_word = 8'h30;
    for (int w = 0; w < 5; w++) src.push_back(first_word + DW'(w));
    repeat (20) tick();
    check("bp_cnt", bus.pop_cnt, 9);
    check("bp_valid", bus.m_valid, 1);
    check("bp_head", bus.m_data, first_word);
    check("bp_left", src.size(), 3);
    drain("bp_done");
    check("bp_cnt_end", bus.pop_cnt, 12);

    // enable dropped during the POP cycle
    for (int w = 0; w < 3; w++) src.push_back(8'h70 + DW'(w));
    wait_rinc("en_drop_rinc");
    en_r   = 0;
    bus.en = 1'b0;
    repeat (12) tick();
    check("en_drop_left", src.size(), 2);
    check("en_drop_cnt", bus.pop_cnt, 13);

    // reset asserted mid-pop
    en_r = 1;
    wait_rinc("rst_pop_rinc");
    #2 R_RST = 1'b0;
    #1;
    check("rstpop_rinc", bus.rinc, 0);
    check("rstpop_busy", bus.busy, 0);
    check("rstpop_valid", bus.m_valid, 0);
    check("rstpop_data", bus.m_data, 0);
    check("rstpop_cnt", bus.pop_cnt, 0);
    repeat (3) tick();
    R_RST = 1'b1;
    repeat (3) tick();

    // counter wrap with a 4-bit counter
    for (int w = 0; w < 17; w++) src.push_back(DW'($urandom));
    drain("wrap_done");
    check("wrap_cnt", bus.pop_cnt, 1);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      en_r  = ($urandom_range(0, 7) != 0);
      rdy_r = 1'($urandom);
      if (src.size() < 8 && $urandom_range(0, 2) == 0) src.push_back(DW'($urandom));
      tick();
    end
    drain("rand_done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
